forward_source_tracker: RTL

- Producer side of the operand-bypass path.
- Tracks in-flight register writes through STAGES pipeline stages (stage 0 = youngest, e.g. EX; stage STAGES-1 = oldest, e.g. WB).
- For each decode-stage source register, generates the per-stage match vector that drives the priority bypass selector's select inputs. Index 0 has highest priority; port STAGES is the register-file fallback.
- Raises a stall when the youngest matching producer has not yet produced its result.

---
 rtl/forward_source_tracker.sv | 70 +++++++
 1 files changed

// File: rtl/forward_source_tracker.sv
// Producer-side bypass tracker: records in-flight register writes per pipeline stage and
// produces per-source stage match vectors plus a load-use stall for the bypass selector.
module forward_source_tracker #(
    parameter int STAGES   = 3,
    parameter int NUM_SRC  = 2,
    parameter int REG_BITS = 5,
    parameter int RS_BITS  = 2
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               issue_valid,
    input  logic [REG_BITS-1:0]                issue_dest,
    input  logic [RS_BITS-1:0]                 issue_ready_stage,
    input  logic                               advance,
    input  logic                               flush,
    input  logic [NUM_SRC-1:0][REG_BITS-1:0]   src_reg,
    output logic [NUM_SRC-1:0][STAGES-1:0]     fwd_select,
    output logic                               fwd_stall
);

    logic [STAGES-1:0]   vld_p0;
    logic [REG_BITS-1:0] dest_p0 [STAGES];
    logic [RS_BITS-1:0]  rdy_p0  [STAGES];

    // Valid bits carry all control meaning; a write to $0 is never tracked.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            vld_p0 <= '0;
        end else if (advance) begin
            vld_p0[0] <= issue_valid && (issue_dest != '0);
            for (int i = 1; i < STAGES; i++) begin
                vld_p0[i] <= vld_p0[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            dest_p0[0] <= issue_dest;
            rdy_p0[0]  <= issue_ready_stage;
            for (int i = 1; i < STAGES; i++) begin
                dest_p0[i] <= dest_p0[i-1];
                rdy_p0[i]  <= rdy_p0[i-1];
            end
        end
    end

    // Lookup stage: only the youngest hit decides whether the operand is available yet.
    always_comb begin
        logic found;
        fwd_select = '0;
        fwd_stall  = 1'b0;
        found      = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            found = 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                if (vld_p0[k] && (dest_p0[k] == src_reg[s]) && (src_reg[s] != '0)) begin
                    fwd_select[s][k] = 1'b1;
                    if (!found) begin
                        found = 1'b1;
                        if (int'(rdy_p0[k]) > k) begin
                            fwd_stall = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
